// File: rtl/ej32_xu_sched.sv
// Two-requester scheduler for the extended arithmetic unit (mul/div/rem/shifts).
// Round-robin grant, one operation in flight, div/rem busy wait with timeout abort.
module ej32_xu_sched #(
  parameter int DSZ = 32,
  parameter int TMO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       rq_v,
  input  logic [5:0]       rq_op,
  input  logic [2*DSZ-1:0] rq_s,
  input  logic [2*DSZ-1:0] rq_t,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             err,
  output logic [DSZ-1:0]   res,
  output logic             xu_start,
  output logic [2:0]       xu_op,
  output logic [DSZ-1:0]   xu_s,
  output logic [DSZ-1:0]   xu_t,
  input  logic             xu_busy,
  input  logic [DSZ-1:0]   xu_res
);
  localparam int NREQ = 2;
  localparam int CW   = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} st_t;

  st_t                       st;
  logic                      lp, win, nxt;
  logic [CW-1:0]             cnt;
  logic [DSZ-1:0]            r_q;
  logic                      e_q;
  logic [NREQ-1:0][2:0]      op_a;
  logic [NREQ-1:0][DSZ-1:0]  s_a, t_a;
  logic                      op_div, op_bad, t_zero;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign op_a[i] = rq_op[3*i +: 3];
    assign s_a[i]  = rq_s[DSZ*i +: DSZ];
    assign t_a[i]  = rq_t[DSZ*i +: DSZ];
  end

  // On conflict the requester that was not served last wins.
  assign nxt    = (&rq_v) ? ~lp : rq_v[1];
  assign op_div = (xu_op == 3'd1) || (xu_op == 3'd2);
  assign op_bad = xu_op[2] & xu_op[1];
  assign t_zero = (xu_t == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      res      <= '0;
      xu_start <= 1'b0;
      xu_op    <= '0;
      xu_s     <= '0;
      xu_t     <= '0;
      lp       <= 1'b1;
      win      <= 1'b0;
      cnt      <= '0;
      r_q      <= '0;
      e_q      <= 1'b0;
    end else begin
      gnt      <= '0;
      done     <= '0;
      xu_start <= 1'b0;
      case (st)
        IDLE: if (|rq_v) begin
          win   <= nxt;
          gnt   <= nxt ? 2'b10 : 2'b01;
          xu_op <= op_a[nxt];
          xu_s  <= s_a[nxt];
          xu_t  <= t_a[nxt];
          st    <= ISSUE;
        end
        ISSUE: begin
          if (op_bad || (op_div && t_zero)) begin
            r_q <= '0;
            e_q <= 1'b1;
            st  <= DONE;
          end else begin
            xu_start <= 1'b1;
            if (op_div) begin
              cnt <= '0;
              st  <= WAIT;
            end else begin
              // Combinational ops: unit output is already valid from the latched operands.
              r_q <= xu_res;
              e_q <= 1'b0;
              st  <= DONE;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // First WAIT cycle covers the unit's busy latency, so busy is not trusted yet.
          if ((cnt != '0) && !xu_busy) begin
            r_q <= xu_res;
            e_q <= 1'b0;
            st  <= DONE;
          end else if (cnt == CW'(TMO - 1)) begin
            r_q <= '0;
            e_q <= 1'b1;
            st  <= DONE;
          end
        end
        DONE: begin
          done <= win ? 2'b10 : 2'b01;
          res  <= r_q;
          err  <= e_q;
          lp   <= win;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ej32_xu_sched.sv
// Bench for ej32_xu_sched: timeline model of expected pulses/results plus a behavioural unit.
module tb_ej32_xu_sched;
  localparam int DSZ = 32;
  localparam int TMO = 64;
  localparam int N   = 4096;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       rq_v = '0;
  logic [5:0]       rq_op = '0;
  logic [2*DSZ-1:0] rq_s = '0;
  logic [2*DSZ-1:0] rq_t = '0;
  logic [1:0]       gnt, done;
  logic             err, xu_start, xu_busy;
  logic [DSZ-1:0]   res, xu_s, xu_t, xu_res;
  logic [2:0]       xu_op;

  always #5 clk = ~clk;

  ej32_xu_sched #(.DSZ(DSZ), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rq_v(rq_v), .rq_op(rq_op), .rq_s(rq_s), .rq_t(rq_t),
    .gnt(gnt), .done(done), .err(err), .res(res), .xu_start(xu_start), .xu_op(xu_op),
    .xu_s(xu_s), .xu_t(xu_t), .xu_busy(xu_busy), .xu_res(xu_res)
  );

  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] s, input logic [31:0] t);
    case (op)
      3'd0: return s * t;
      3'd1: return (t == 0) ? 32'd0 : 32'($signed(s) / $signed(t));
      3'd2: return (t == 0) ? 32'd0 : 32'($signed(s) % $signed(t));
      3'd3: return s << t[4:0];
      3'd4: return 32'($signed(s) >>> t[4:0]);
      3'd5: return s >> t[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural unit: busy for busy_len cycles counted from the xu_start cycle.
  int busy_len = 0;
  int ucnt = 0;
  always @(posedge clk) begin
    if (xu_start) ucnt <= 1;
    else if (ucnt < 1000000) ucnt <= ucnt + 1;
  end
  always_comb begin
    xu_busy = ((xu_op == 3'd1) || (xu_op == 3'd2)) && ((xu_start ? 0 : ucnt) < busy_len);
    xu_res  = golden(xu_op, xu_s, xu_t);
  end

  // Model: expected events per cycle index (interval after posedge number cyc).
  bit [1:0]  g_a [N];
  bit [1:0]  d_a [N];
  bit        s_a [N];
  bit        e_a [N];
  bit [31:0] r_a [N];
  int cyc = 0, free_from = 0, x_from = -1, x_to = -1;
  bit lp_m = 1'b1;
  logic [2:0]  x_op = '0;
  logic [31:0] x_s = '0, x_t = '0;
  int m_w, m_k, m_g, m_d;
  logic [2:0]  m_op;
  logic [31:0] m_s, m_t;
  bit m_bad, m_e;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && (cyc - 1) >= free_from && rq_v != 2'b00 && cyc + 200 < N) begin
      m_w   = (rq_v == 2'b11) ? (lp_m ? 0 : 1) : (rq_v[1] ? 1 : 0);
      m_op  = rq_op[3*m_w +: 3];
      m_s   = rq_s[32*m_w +: 32];
      m_t   = rq_t[32*m_w +: 32];
      m_bad = (m_op > 3'd5) || ((m_op == 3'd1 || m_op == 3'd2) && m_t == 0);
      m_e   = m_bad;
      m_k   = 0;
      if (!m_bad && (m_op == 3'd1 || m_op == 3'd2)) begin
        m_k = ((busy_len < 1) ? 1 : busy_len) + 1;
        if (m_k > TMO) begin m_k = TMO; m_e = 1'b1; end
      end
      m_g = cyc;
      m_d = m_g + 2 + m_k;
      g_a[m_g] = m_w[0] ? 2'b10 : 2'b01;
      if (!m_bad) s_a[m_g + 1] = 1'b1;
      d_a[m_d] = g_a[m_g];
      e_a[m_d] = m_e;
      r_a[m_d] = m_e ? 32'd0 : golden(m_op, m_s, m_t);
      free_from = m_d;
      lp_m = m_w[0];
      x_from = m_g; x_to = m_d; x_op = m_op; x_s = m_s; x_t = m_t;
    end
  end

  always @(negedge rst_n) begin
    for (int c = cyc; c < N; c++) begin g_a[c] = '0; d_a[c] = '0; s_a[c] = 1'b0; end
    free_from = cyc;
    lp_m = 1'b1;
    x_to = cyc;
  end

  int pass_n = 0, tot_n = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else pass_n++;
  endtask

  int done_cnt = 0, last_gnt_cyc = 0, last_done_cyc = 0, last_start_cyc = -1;
  logic [1:0]  last_gnt = '0;
  logic [31:0] last_res = '0;
  logic        last_err = 1'b0;
  logic [1:0]  gq [$];
  logic [31:0] exp_res = '0;
  logic        exp_err = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      chk("rst_ctl", {gnt, done, err, xu_start, xu_op}, '0);
      chk("rst_res", res, '0);
      chk("rst_xu", {xu_s, xu_t}, '0);
      exp_res = '0;
      exp_err = 1'b0;
    end else if (cyc < N) begin
      if (d_a[cyc] != 2'b00) begin exp_res = r_a[cyc]; exp_err = e_a[cyc]; end
      chk("gnt", gnt, g_a[cyc]);
      chk("done", done, d_a[cyc]);
      chk("xu_start", xu_start, s_a[cyc]);
      chk("res", res, exp_res);
      chk("err", err, exp_err);
      if (cyc >= x_from && cyc < x_to) begin
        chk("xu_op", xu_op, x_op);
        chk("xu_s", xu_s, x_s);
        chk("xu_t", xu_t, x_t);
      end
      if (gnt != 2'b00) begin last_gnt = gnt; last_gnt_cyc = cyc; gq.push_back(gnt); end
      if (xu_start) last_start_cyc = cyc;
      if (done != 2'b00) begin last_done_cyc = cyc; last_res = res; last_err = err; done_cnt++; end
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] s, input logic [31:0] t);
    rq_op[3*r +: 3]  = op;
    rq_s[32*r +: 32] = s;
    rq_t[32*r +: 32] = t;
    rq_v[r] = 1'b1;
  endtask

  // drop=1: scramble the granted lane after its grant and release rq_v on done.
  task automatic wait_done(input int n, input bit drop);
    int base, lim;
    base = done_cnt;
    lim = 0;
    while (done_cnt < base + n && lim < 300) begin
      tick();
      lim++;
      if (drop) begin
        for (int r = 0; r < 2; r++)
          if (gnt[r]) begin
            rq_op[3*r +: 3]  = 3'($urandom);
            rq_s[32*r +: 32] = $urandom;
            rq_t[32*r +: 32] = $urandom;
          end
        rq_v = rq_v & ~done;
      end
    end
    if (done_cnt < base + n) chk("done_bound", done_cnt - base, n);
  endtask

  int base_d;

  initial begin
    repeat (3) tick();
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_res", res, 32'd0);
    rst_n = 1'b1;
    tick();

    set_req(0, 3'd0, 32'd7, 32'd6);
    wait_done(1, 1);
    chk("mul_gnt", last_gnt, 2'b01);
    chk("mul_start_lat", last_start_cyc - last_gnt_cyc, 1);
    chk("mul_lat", last_done_cyc - last_gnt_cyc, 2);
    chk("mul_res", last_res, 32'd42);
    chk("mul_err", last_err, 1'b0);

    busy_len = 5;
    set_req(0, 3'd1, 32'd100, 32'd7);
    wait_done(1, 1);
    chk("div_res", last_res, 32'd14);
    chk("div_lat", last_done_cyc - last_gnt_cyc, 8);
    chk("div_err", last_err, 1'b0);

    busy_len = 0;
    set_req(1, 3'd2, 32'd55, 32'd0);
    wait_done(1, 1);
    chk("dz_gnt", last_gnt, 2'b10);
    chk("dz_lat", last_done_cyc - last_gnt_cyc, 2);
    chk("dz_err", last_err, 1'b1);
    chk("dz_res", last_res, 32'd0);
    chk("dz_nostart", last_start_cyc < last_gnt_cyc, 1'b1);

    set_req(0, 3'd6, 32'd1, 32'd2);
    wait_done(1, 1);
    chk("ill_err", last_err, 1'b1);

    set_req(1, 3'd4, 32'hF000_0000, 32'd4);
    wait_done(1, 1);
    chk("shr_res", last_res, 32'hFF00_0000);
    set_req(0, 3'd5, 32'hF000_0000, 32'd4);
    wait_done(1, 1);
    chk("ushr_res", last_res, 32'h0F00_0000);
    set_req(1, 3'd3, 32'd3, 32'd35);
    wait_done(1, 1);
    chk("shl_res", last_res, 32'd24);

    busy_len = 2;
    set_req(0, 3'd2, -32'sd17, 32'd5);
    wait_done(1, 1);
    chk("rem_res", last_res, 32'hFFFF_FFFE);
    chk("rem_lat", last_done_cyc - last_gnt_cyc, 5);

    busy_len = 0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    gq.delete();
    set_req(0, 3'd0, 32'd2, 32'd3);
    set_req(1, 3'd0, 32'd4, 32'd5);
    wait_done(3, 0);
    rq_v = 2'b00;
    chk("rr_count", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("rr_0", gq[0], 2'b01);
      chk("rr_1", gq[1], 2'b10);
      chk("rr_2", gq[2], 2'b01);
    end
    chk("rr_res", last_res, 32'd6);
    tick();

    busy_len = 1000;
    set_req(0, 3'd1, 32'd9, 32'd3);
    wait_done(1, 1);
    chk("tmo_lat", last_done_cyc - last_gnt_cyc, 66);
    chk("tmo_err", last_err, 1'b1);
    chk("tmo_res", last_res, 32'd0);
    busy_len = 0;
    set_req(1, 3'd0, 32'd11, 32'd11);
    wait_done(1, 1);
    chk("post_tmo_res", last_res, 32'd121);
    chk("post_tmo_err", last_err, 1'b0);

    busy_len = 1000;
    set_req(0, 3'd1, 32'd50, 32'd5);
    repeat (10) tick();
    base_d = done_cnt;
    rst_n = 1'b0;
    rq_v = 2'b00;
    #1;
    chk("abort_xu_s", xu_s, 32'd0);
    chk("abort_res", res, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_nodone", done_cnt, base_d);
    busy_len = 0;
    set_req(0, 3'd0, 32'd3, 32'd5);
    wait_done(1, 1);
    chk("post_rst_res", last_res, 32'd15);
    chk("post_rst_lat", last_done_cyc - last_gnt_cyc, 2);

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
